// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage registers: state encoding,
// default widths and control-bit positions used by every stage.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipeState_e;

  localparam int DATA_W_DEF = 96;
  localparam int CTRL_W_DEF = 8;
  localparam int PC_W_DEF   = 32;
  localparam int CNT_W_DEF  = 16;

  localparam int CTRL_REGWRITE   = 0;
  localparam int CTRL_MEMREAD    = 1;
  localparam int CTRL_MEMWRITE   = 2;
  localparam int CTRL_MEMTOREG   = 3;
  localparam int CTRL_BRANCH     = 4;
  localparam int CTRL_INVERTZERO = 5;
  localparam int CTRL_JUMP       = 6;
  localparam int CTRL_ZERO       = 7;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: valid/ctrl/data/pc with load and clear. Clearing zeroes
// the control bits so an invalid entry can never carry live write enables.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int PC_W   = PC_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] inCtrl,
  input  logic [DATA_W-1:0] inData,
  input  logic [PC_W-1:0]   inPc,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data,
  output logic [PC_W-1:0]   pc
);

  // Clear wins over load; data/pc are left stale on clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
      pc    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= inCtrl;
      data  <= inData;
      pc    <= inPc;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage register with optional skid entry (registered in_ready),
// flush with control squash and a saturating back-pressure counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int PC_W   = PC_W_DEF,
  parameter int SKID   = 1,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              accept, emit;
  logic              mainLoad, mainClear, mainValid;
  logic [CTRL_W-1:0] mainCtrlIn;
  logic [DATA_W-1:0] mainDataIn;
  logic [PC_W-1:0]   mainPcIn;

  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;
  assign out_valid = mainValid;

  pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .PC_W(PC_W)) uMain (
    .clock (clock),     .reset (reset),
    .load  (mainLoad),  .clear (mainClear),
    .inCtrl(mainCtrlIn), .inData(mainDataIn), .inPc(mainPcIn),
    .valid (mainValid), .ctrl  (out_ctrl), .data(out_data), .pc(out_pc)
  );

  generate
    if (SKID != 0) begin : gSkid
      pipeState_e        state, nextState;
      logic              readyQ, skidLoad, skidClear, mainFromSkid, skidValid;
      logic [CTRL_W-1:0] skidCtrl;
      logic [DATA_W-1:0] skidData;
      logic [PC_W-1:0]   skidPc;

      pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .PC_W(PC_W)) uSkid (
        .clock (clock),    .reset (reset),
        .load  (skidLoad), .clear (skidClear),
        .inCtrl(in_ctrl),  .inData(in_data), .inPc(in_pc),
        .valid (skidValid), .ctrl (skidCtrl), .data(skidData), .pc(skidPc)
      );

      // in_ready is precomputed from the next state so it never sees out_ready.
      always_ff @(posedge clock) begin
        if (reset) begin
          state  <= ST_EMPTY;
          readyQ <= 1'b1;
        end else begin
          state  <= nextState;
          readyQ <= (nextState != ST_TWO);
        end
      end

      always_comb begin
        nextState    = state;
        mainLoad     = 1'b0;
        mainClear    = 1'b0;
        skidLoad     = 1'b0;
        skidClear    = 1'b0;
        mainFromSkid = 1'b0;
        case (state)
          ST_EMPTY: if (accept) begin
            mainLoad  = 1'b1;
            nextState = ST_ONE;
          end
          ST_ONE: begin
            if (accept && emit) begin
              mainLoad = 1'b1;
            end else if (accept) begin
              skidLoad  = 1'b1;
              nextState = ST_TWO;
            end else if (emit) begin
              mainClear = 1'b1;
              nextState = ST_EMPTY;
            end
          end
          ST_TWO: if (emit) begin
            mainLoad     = 1'b1;
            mainFromSkid = 1'b1;
            skidClear    = 1'b1;
            nextState    = ST_ONE;
          end
          default: nextState = ST_EMPTY;
        endcase
        if (flush) begin
          mainLoad  = 1'b0;
          skidLoad  = 1'b0;
          mainClear = 1'b1;
          skidClear = 1'b1;
          nextState = ST_EMPTY;
        end
      end

      assign in_ready   = readyQ;
      assign mainCtrlIn = mainFromSkid ? skidCtrl : in_ctrl;
      assign mainDataIn = mainFromSkid ? skidData : in_data;
      assign mainPcIn   = mainFromSkid ? skidPc   : in_pc;
      assign occupancy  = {1'b0, mainValid} + {1'b0, skidValid};
    end else begin : gReg
      assign in_ready   = !mainValid || out_ready;
      assign mainLoad   = accept && !flush;
      assign mainClear  = flush || (emit && !accept);
      assign mainCtrlIn = in_ctrl;
      assign mainDataIn = in_data;
      assign mainPcIn   = in_pc;
      assign occupancy  = {1'b0, mainValid};
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a skid instance (4-bit stall counter) checked by a
// vector table plus scoreboard, and a single-register instance checked by hand.
module tb_pipe_stage_skid;

  localparam int DW = 96;
  localparam int CW = 8;
  localparam int PW = 32;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic          aFlush, aInValid, aInReady, aOutValid, aOutReady;
  logic [CW-1:0] aInCtrl, aOutCtrl;
  logic [DW-1:0] aInData, aOutData;
  logic [PW-1:0] aInPc, aOutPc;
  logic [1:0]    aOcc;
  logic [3:0]    aStall;

  logic          bFlush, bInValid, bInReady, bOutValid, bOutReady;
  logic [CW-1:0] bInCtrl, bOutCtrl;
  logic [DW-1:0] bInData, bOutData;
  logic [PW-1:0] bInPc, bOutPc;
  logic [1:0]    bOcc;
  logic [15:0]   bStall;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .PC_W(PW), .SKID(1), .CNT_W(4)) dutA (
    .clock(clock), .reset(reset), .flush(aFlush),
    .in_valid(aInValid), .in_ready(aInReady), .in_ctrl(aInCtrl), .in_data(aInData), .in_pc(aInPc),
    .out_valid(aOutValid), .out_ready(aOutReady), .out_ctrl(aOutCtrl), .out_data(aOutData),
    .out_pc(aOutPc), .occupancy(aOcc), .stall_cnt(aStall)
  );

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .PC_W(PW), .SKID(0), .CNT_W(16)) dutB (
    .clock(clock), .reset(reset), .flush(bFlush),
    .in_valid(bInValid), .in_ready(bInReady), .in_ctrl(bInCtrl), .in_data(bInData), .in_pc(bInPc),
    .out_valid(bOutValid), .out_ready(bOutReady), .out_ctrl(bOutCtrl), .out_data(bOutData),
    .out_pc(bOutPc), .occupancy(bOcc), .stall_cnt(bStall)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] ctrlOf(input logic [PW-1:0] pc);
    return pc[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [DW-1:0] dataOf(input logic [PW-1:0] pc);
    return {pc, ~pc, pc ^ 32'hA5A5_0000};
  endfunction

  task automatic driveA(input logic v, input logic [PW-1:0] pc, input logic r, input logic f);
    aInValid = v; aInPc = pc; aInCtrl = ctrlOf(pc); aInData = dataOf(pc);
    aOutReady = r; aFlush = f;
  endtask

  task automatic driveB(input logic v, input logic [PW-1:0] pc, input logic r, input logic f);
    bInValid = v; bInPc = pc; bInCtrl = ctrlOf(pc); bInData = dataOf(pc);
    bOutReady = r; bFlush = f;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard for dutA: accepts are queued, emits must match in order.
  logic [PW-1:0] sbq[$];
  logic [PW-1:0] sbExp;
  always @(negedge clock) begin
    if (reset || aFlush) begin
      sbq.delete();
    end else begin
      if (aOutValid && aOutReady) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sbEmit: unexpected pc %0h, expected none", aOutPc);
        end else begin
          sbExp = sbq.pop_front();
          check("sbPc", aOutPc, sbExp);
          check("sbCtrl", aOutCtrl, ctrlOf(sbExp));
          check("sbData", aOutData, dataOf(sbExp));
        end
      end
      if (aInValid && aInReady) sbq.push_back(aInPc);
    end
  end

  typedef struct {
    logic          inV;
    logic [PW-1:0] pc;
    logic          oR;
    logic          expOV;
    logic [PW-1:0] expPc;
    logic [1:0]    expOcc;
    logic          expInR;
    logic [3:0]    expStall;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // Streaming, then back-pressure into TWO with an offer refused while full.
    vecs[0]  = '{1'b1, 32'h100, 1'b1, 1'b1, 32'h100, 2'd1, 1'b1, 4'd0};
    vecs[1]  = '{1'b1, 32'h104, 1'b1, 1'b1, 32'h104, 2'd1, 1'b1, 4'd0};
    vecs[2]  = '{1'b1, 32'h108, 1'b1, 1'b1, 32'h108, 2'd1, 1'b1, 4'd0};
    vecs[3]  = '{1'b0, 32'h000, 1'b1, 1'b0, 32'h000, 2'd0, 1'b1, 4'd0};
    vecs[4]  = '{1'b1, 32'h200, 1'b0, 1'b1, 32'h200, 2'd1, 1'b1, 4'd0};
    vecs[5]  = '{1'b1, 32'h204, 1'b0, 1'b1, 32'h200, 2'd2, 1'b0, 4'd1};
    vecs[6]  = '{1'b1, 32'h2FF, 1'b0, 1'b1, 32'h200, 2'd2, 1'b0, 4'd2};
    vecs[7]  = '{1'b0, 32'h000, 1'b0, 1'b1, 32'h200, 2'd2, 1'b0, 4'd3};
    vecs[8]  = '{1'b0, 32'h000, 1'b0, 1'b1, 32'h200, 2'd2, 1'b0, 4'd4};
    vecs[9]  = '{1'b0, 32'h000, 1'b0, 1'b1, 32'h200, 2'd2, 1'b0, 4'd5};
    vecs[10] = '{1'b0, 32'h000, 1'b1, 1'b1, 32'h204, 2'd1, 1'b1, 4'd5};
    vecs[11] = '{1'b0, 32'h000, 1'b1, 1'b0, 32'h000, 2'd0, 1'b1, 4'd5};

    reset = 1'b1;
    driveA(1'b0, '0, 1'b0, 1'b0);
    driveB(1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check("rstA.outValid", aOutValid, 0);
    check("rstA.outCtrl", aOutCtrl, 0);
    check("rstA.outData", aOutData, 0);
    check("rstA.occ", aOcc, 0);
    check("rstA.inReady", aInReady, 1);
    check("rstA.stall", aStall, 0);
    check("rstB.outValid", bOutValid, 0);
    check("rstB.inReady", bInReady, 1);
    check("rstB.occ", bOcc, 0);

    for (int i = 0; i < 12; i++) begin
      driveA(vecs[i].inV, vecs[i].pc, vecs[i].oR, 1'b0);
      tick();
      check($sformatf("vec%0d.outValid", i), aOutValid, vecs[i].expOV);
      check($sformatf("vec%0d.occ", i), aOcc, vecs[i].expOcc);
      check($sformatf("vec%0d.inReady", i), aInReady, vecs[i].expInR);
      check($sformatf("vec%0d.stall", i), aStall, vecs[i].expStall);
      if (vecs[i].expOV) begin
        check($sformatf("vec%0d.outPc", i), aOutPc, vecs[i].expPc);
        check($sformatf("vec%0d.outCtrl", i), aOutCtrl, ctrlOf(vecs[i].expPc));
      end else begin
        check($sformatf("vec%0d.outCtrlZero", i), aOutCtrl, 0);
      end
    end

    // Flush alongside an accept: the held entry and the new one are both gone.
    driveA(1'b1, 32'h300, 1'b0, 1'b0);
    tick();
    check("flushPre.occ", aOcc, 1);
    aInValid = 1'b1; aInPc = 32'h304; aInCtrl = 8'hFF; aFlush = 1'b1; aOutReady = 1'b0;
    tick();
    driveA(1'b0, '0, 1'b1, 1'b0);
    check("flush.outValid", aOutValid, 0);
    check("flush.outCtrl", aOutCtrl, 0);
    check("flush.occ", aOcc, 0);
    check("flush.inReady", aInReady, 1);
    check("flush.stallKept", aStall, 6);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("flushPost%0d.outValid", k), aOutValid, 0);
    end

    // Saturation with the buffer full, then reset mid-stall.
    driveA(1'b1, 32'h400, 1'b0, 1'b0);
    tick();
    driveA(1'b1, 32'h404, 1'b0, 1'b0);
    tick();
    driveA(1'b0, '0, 1'b0, 1'b0);
    repeat (20) tick();
    check("sat.stall", aStall, 15);
    check("sat.occ", aOcc, 2);
    tick();
    check("sat.stallHold", aStall, 15);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midRst.outValid", aOutValid, 0);
    check("midRst.outCtrl", aOutCtrl, 0);
    check("midRst.outData", aOutData, 0);
    check("midRst.outPc", aOutPc, 0);
    check("midRst.occ", aOcc, 0);
    check("midRst.stall", aStall, 0);
    check("midRst.inReady", aInReady, 1);

    // Recovery stream after reset; ordering covered by the scoreboard.
    driveA(1'b1, 32'h700, 1'b1, 1'b0);
    tick();
    driveA(1'b1, 32'h704, 1'b1, 1'b0);
    tick();
    check("recover.outPc", aOutPc, 32'h704);
    driveA(1'b0, '0, 1'b1, 1'b0);
    repeat (2) tick();
    check("sbDrain", sbq.size(), 0);

    // Single-register mode: combinational in_ready and bubble-free swap.
    driveB(1'b1, 32'h500, 1'b0, 1'b0);
    tick();
    check("b0.outValid", bOutValid, 1);
    check("b0.outPc", bOutPc, 32'h500);
    check("b0.occ", bOcc, 1);
    driveB(1'b1, 32'h504, 1'b0, 1'b0);
    #1;
    check("b.inReadyLow", bInReady, 0);
    bOutReady = 1'b1;
    #1;
    check("b.inReadyComb", bInReady, 1);
    tick();
    check("bSwap.outValid", bOutValid, 1);
    check("bSwap.outPc", bOutPc, 32'h504);
    check("bSwap.outCtrl", bOutCtrl, ctrlOf(32'h504));
    check("bSwap.occ", bOcc, 1);
    for (int k = 0; k < 3; k++) begin
      driveB(1'b1, 32'h600 + 32'(4 * k), 1'b1, 1'b0);
      tick();
      check($sformatf("bStream%0d.outValid", k), bOutValid, 1);
      check($sformatf("bStream%0d.outPc", k), bOutPc, 32'h600 + 32'(4 * k));
    end
    driveB(1'b0, '0, 1'b1, 1'b0);
    tick();
    check("bDrain.outValid", bOutValid, 0);
    check("bDrain.outCtrl", bOutCtrl, 0);
    check("bDrain.occ", bOcc, 0);
    driveB(1'b1, 32'h800, 1'b0, 1'b1);
    tick();
    check("bFlush.outValid", bOutValid, 0);
    check("bFlush.occ", bOcc, 0);
    driveB(1'b1, 32'h900, 1'b0, 1'b0);
    tick();
    driveB(1'b0, '0, 1'b0, 1'b0);
    repeat (3) tick();
    check("bStall.cnt", bStall, 3);
    check("bStall.outPc", bOutPc, 32'h900);
    bOutReady = 1'b1;
    tick();
    check("bEnd.outValid", bOutValid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
